// File: rtl/updown_step_sched.sv
// Two-client round-robin scheduler that paces step jobs as single step_en pulses
// while tracking the 2-bit phase and a wider position register.
module updown_step_sched #(
   parameter int N_W   = 4,
   parameter int POS_W = 8,
   parameter int DIV   = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_a,
   input  logic             dir_a,
   input  logic [N_W-1:0]   num_a,
   input  logic             req_b,
   input  logic             dir_b,
   input  logic [N_W-1:0]   num_b,
   input  logic             abort,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             done_a,
   output logic             done_b,
   output logic             busy,
   output logic             step_en,
   output logic             step_dir,
   output logic [1:0]       phase,
   output logic [POS_W-1:0] pos
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_STEP,
      S_WAIT,
      S_DONE
   } state_t;

   // Divider only ever holds DIV-1 down to 1, so size it for DIV-1.
   localparam int              DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV - 1);

   state_t             state_q, state_d;
   logic               owner_q, owner_d;          // 0 = A, 1 = B
   logic               last_owner_q, last_owner_d;
   logic               dir_q, dir_d;
   logic [N_W-1:0]     num_q, num_d;
   logic [N_W-1:0]     rem_q, rem_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [1:0]         phase_q, phase_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic               win_b;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         dir_q        <= 1'b0;
         num_q        <= '0;
         rem_q        <= '0;
         div_q        <= '0;
         phase_q      <= 2'd0;
         pos_q        <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         dir_q        <= dir_d;
         num_q        <= num_d;
         rem_q        <= rem_d;
         div_q        <= div_d;
         phase_q      <= phase_d;
         pos_q        <= pos_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      dir_d        = dir_q;
      num_d        = num_q;
      rem_d        = rem_q;
      div_d        = div_q;
      phase_d      = phase_q;
      pos_d        = pos_q;
      // On a tie, B wins only when A held the previous grant.
      win_b        = req_b && (!req_a || !last_owner_q);

      case (state_q)
         S_IDLE: begin
            if (req_a || req_b) begin
               owner_d      = win_b;
               last_owner_d = win_b;
               dir_d        = win_b ? dir_b : dir_a;
               num_d        = win_b ? num_b : num_a;
               state_d      = S_GRANT;
            end
         end
         S_GRANT: begin
            if (num_q == '0) begin
               state_d = S_DONE;
            end else begin
               rem_d   = num_q;
               state_d = S_STEP;
            end
         end
         S_STEP: begin
            phase_d = dir_q ? phase_q - 2'd1 : phase_q + 2'd1;
            pos_d   = dir_q ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
            rem_d   = rem_q - N_W'(1);
            if (rem_q == N_W'(1)) begin
               state_d = S_DONE;
            end else if (DIV == 1) begin
               state_d = S_STEP;
            end else begin
               div_d   = DIV_LOAD;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            div_d = div_q - DIV_W'(1);
            if (abort) begin
               rem_d   = '0;
               div_d   = '0;
               state_d = S_DONE;
            end else if (div_q <= DIV_W'(1)) begin
               state_d = S_STEP;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign gnt_a    = (state_q == S_GRANT) && !owner_q;
   assign gnt_b    = (state_q == S_GRANT) &&  owner_q;
   assign done_a   = (state_q == S_DONE)  && !owner_q;
   assign done_b   = (state_q == S_DONE)  &&  owner_q;
   assign busy     = (state_q != S_IDLE);
   assign step_en  = (state_q == S_STEP);
   assign step_dir = dir_q;
   assign phase    = phase_q;
   assign pos      = pos_q;

endmodule

// File: tb/tb_updown_step_sched.sv
// Directed bench for updown_step_sched: DIV=3 instance for most scenarios,
// DIV=1 instance for back-to-back stepping.
module tb_updown_step_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_a, dir_a, req_b, dir_b, abort;
   logic [3:0] num_a, num_b;

   logic       gnt_a3, gnt_b3, done_a3, done_b3, busy3, step_en3, step_dir3;
   logic [1:0] phase3;
   logic [7:0] pos3;
   logic       gnt_a1, gnt_b1, done_a1, done_b1, busy1, step_en1, step_dir1;
   logic [1:0] phase1;
   logic [7:0] pos1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_gnt_a, m_gnt_b, m_done_a, m_done_b, m_busy, m_step, m_dir;
   logic [31:0] ph_trail, pos_trail;

   always #5 clk = ~clk;

   updown_step_sched #(.N_W(4), .POS_W(8), .DIV(3)) dut3 (
      .clk(clk), .reset(reset),
      .req_a(req_a), .dir_a(dir_a), .num_a(num_a),
      .req_b(req_b), .dir_b(dir_b), .num_b(num_b),
      .abort(abort),
      .gnt_a(gnt_a3), .gnt_b(gnt_b3), .done_a(done_a3), .done_b(done_b3),
      .busy(busy3), .step_en(step_en3), .step_dir(step_dir3),
      .phase(phase3), .pos(pos3)
   );

   updown_step_sched #(.N_W(4), .POS_W(8), .DIV(1)) dut1 (
      .clk(clk), .reset(reset),
      .req_a(req_a), .dir_a(dir_a), .num_a(num_a),
      .req_b(req_b), .dir_b(dir_b), .num_b(num_b),
      .abort(abort),
      .gnt_a(gnt_a1), .gnt_b(gnt_b1), .done_a(done_a1), .done_b(done_b1),
      .busy(busy1), .step_en(step_en1), .step_dir(step_dir1),
      .phase(phase1), .pos(pos1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   // Runs n cycles; bit t of each mask is the output during cycle t after
   // the sampling edge. Trails collect phase/pos in the cycle after each step.
   task automatic run(input int n, input bit hold, input int abort_at, input bit sel);
      logic prev_step;
      logic s_ga, s_gb, s_da, s_db, s_busy, s_step, s_dir;
      logic [1:0] s_ph;
      logic [7:0] s_pos;
      m_gnt_a = '0; m_gnt_b = '0; m_done_a = '0; m_done_b = '0;
      m_busy = '0; m_step = '0; m_dir = '0; ph_trail = '0; pos_trail = '0;
      prev_step = 1'b0;
      for (int t = 1; t <= n; t++) begin
         tick();
         if (!hold && t == 1) begin
            req_a = 1'b0;
            req_b = 1'b0;
         end
         abort  = (t == abort_at);
         s_ga   = sel ? gnt_a1    : gnt_a3;
         s_gb   = sel ? gnt_b1    : gnt_b3;
         s_da   = sel ? done_a1   : done_a3;
         s_db   = sel ? done_b1   : done_b3;
         s_busy = sel ? busy1     : busy3;
         s_step = sel ? step_en1  : step_en3;
         s_dir  = sel ? step_dir1 : step_dir3;
         s_ph   = sel ? phase1    : phase3;
         s_pos  = sel ? pos1      : pos3;
         if (s_ga)   m_gnt_a[t]  = 1'b1;
         if (s_gb)   m_gnt_b[t]  = 1'b1;
         if (s_da)   m_done_a[t] = 1'b1;
         if (s_db)   m_done_b[t] = 1'b1;
         if (s_busy) m_busy[t]   = 1'b1;
         if (s_step) begin
            m_step[t] = 1'b1;
            m_dir[t]  = s_dir;
         end
         if (prev_step) begin
            ph_trail  = (ph_trail << 2) | 32'(s_ph);
            pos_trail = (pos_trail << 8) | 32'(s_pos);
         end
         prev_step = s_step;
      end
      abort = 1'b0;
   endtask

   initial begin
      reset = 1'b0; abort = 1'b0;
      req_a = 1'b0; dir_a = 1'b0; num_a = 4'd0;
      req_b = 1'b0; dir_b = 1'b0; num_b = 4'd0;
      idle(2);
      check("rst_busy",   32'(busy3), 32'h0);
      check("rst_outs",   32'({gnt_a3, gnt_b3, done_a3, done_b3, step_en3, step_dir3}), 32'h0);
      check("rst_phase",  32'(phase3), 32'h0);
      check("rst_pos",    32'(pos3), 32'h0);
      check("rst_busy1",  32'(busy1), 32'h0);
      reset = 1'b1;
      idle(1);

      // Single A job, 3 increments, DIV=3.
      req_a = 1'b1; dir_a = 1'b0; num_a = 4'd3;
      run(12, 1'b0, 0, 1'b0);
      check("t1_gnt_a",  m_gnt_a,  32'h2);
      check("t1_gnt_b",  m_gnt_b,  32'h0);
      check("t1_step",   m_step,   32'h124);
      check("t1_done_a", m_done_a, 32'h200);
      check("t1_busy",   m_busy,   32'h3FE);
      check("t1_phases", ph_trail, 32'h1B);
      check("t1_pos",    pos_trail, 32'h010203);

      // Zero-length B job: grant then done, no step, state kept.
      req_b = 1'b1; dir_b = 1'b0; num_b = 4'd0;
      run(6, 1'b0, 0, 1'b0);
      check("t3_gnt_b",  m_gnt_b,  32'h2);
      check("t3_done_b", m_done_b, 32'h4);
      check("t3_step",   m_step,   32'h0);
      check("t3_busy",   m_busy,   32'h6);
      check("t3_phase",  32'(phase3), 32'h3);
      check("t3_pos",    32'(pos3),   32'h3);

      reset = 1'b0;
      idle(2);
      reset = 1'b1;

      // Both held: A(dec) wins first, then alternation A,B,A,B.
      req_a = 1'b1; dir_a = 1'b1; num_a = 4'd1;
      req_b = 1'b1; dir_b = 1'b0; num_b = 4'd1;
      run(15, 1'b1, 0, 1'b0);
      req_a = 1'b0; req_b = 1'b0;
      check("t2_gnt_a",  m_gnt_a,  32'h202);
      check("t2_gnt_b",  m_gnt_b,  32'h2020);
      check("t2_step",   m_step,   32'h4444);
      check("t2_dir",    m_dir,    32'h0404);
      check("t2_phases", ph_trail, 32'hCC);
      check("t2_pos",    pos_trail, 32'hFF00FF00);
      check("t2_done_b", m_done_b, 32'h8080);
      idle(2);

      // Abort during the WAIT after the second step.
      req_a = 1'b1; dir_a = 1'b0; num_a = 4'd5;
      run(10, 1'b0, 6, 1'b0);
      check("t4_step",   m_step,   32'h24);
      check("t4_done_a", m_done_a, 32'h80);
      check("t4_busy",   m_busy,   32'hFE);
      check("t4_phases", ph_trail, 32'h6);
      check("t4_pos",    pos_trail, 32'h0102);
      idle(2);

      // Abort seen only in a STEP cycle is ignored.
      req_a = 1'b1; dir_a = 1'b0; num_a = 4'd2;
      run(8, 1'b0, 2, 1'b0);
      check("t4b_step",   m_step,   32'h24);
      check("t4b_done_a", m_done_a, 32'h40);
      check("t4b_phases", ph_trail, 32'hC);
      check("t4b_pos",    pos_trail, 32'h0304);
      idle(2);

      // Reset in the middle of a job.
      req_a = 1'b1; dir_a = 1'b0; num_a = 4'd4;
      tick();
      tick();
      tick();
      check("t5_mid_phase", 32'(phase3), 32'h1);
      check("t5_mid_pos",   32'(pos3),   32'h5);
      check("t5_mid_busy",  32'(busy3),  32'h1);
      reset = 1'b0; req_a = 1'b0;
      tick();
      check("t5_busy",  32'(busy3),  32'h0);
      check("t5_phase", 32'(phase3), 32'h0);
      check("t5_pos",   32'(pos3),   32'h0);
      check("t5_outs",  32'({done_a3, step_en3, step_dir3, gnt_a3}), 32'h0);
      reset = 1'b1;
      run(4, 1'b0, 0, 1'b0);
      check("t5_after_busy", m_busy,   32'h0);
      check("t5_after_done", m_done_a, 32'h0);

      // DIV=1: four consecutive step pulses, phase wraps.
      reset = 1'b0;
      idle(2);
      reset = 1'b1;
      req_a = 1'b1; dir_a = 1'b0; num_a = 4'd4;
      run(8, 1'b0, 0, 1'b1);
      check("t6_gnt_a",  m_gnt_a,  32'h2);
      check("t6_step",   m_step,   32'h3C);
      check("t6_done_a", m_done_a, 32'h40);
      check("t6_busy",   m_busy,   32'h7E);
      check("t6_phases", ph_trail, 32'h6C);
      check("t6_pos",    32'(pos1), 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/updown_step_sched.md
Name: updown_step_sched

Overview:
Two-requester scheduler for the 2-bit up/down phase counter. It accepts step jobs from two clients (A, B), each with a direction and a step count. It arbitrates the clients round-robin and issues the granted job as paced single-step pulses. It also keeps its own 2-bit phase and a wider position register, so downstream logic and the bench can check each step.

Parameters:
N_W, 4, width of the step-count field num_a/num_b
POS_W, 8, width of the position register pos
DIV, 3, clock cycles between successive step_en pulses; legal values are 1 or greater

Ports:
clk  in  1  clock, all flops on rising edge
reset  in  1  synchronous, active-low
req_a  in  1  client A job request, level
dir_a  in  1  client A direction: 0 = increment, 1 = decrement
num_a  in  N_W  client A step count
req_b  in  1  client B job request, level
dir_b  in  1  client B direction: 0 = increment, 1 = decrement
num_b  in  N_W  client B step count
abort  in  1  terminate the active job early (active-high)
gnt_a  out  1  one-cycle pulse: A's job accepted
gnt_b  out  1  one-cycle pulse: B's job accepted
done_a  out  1  one-cycle pulse: A's job finished
done_b  out  1  one-cycle pulse: B's job finished
busy  out  1  high whenever state is not IDLE
step_en  out  1  one-cycle step strobe to the counter
step_dir  out  1  direction of the current job; stable for the whole job
phase  out  2  current 2-bit phase
pos  out  POS_W  accumulated position, modulo 2^POS_W

Behaviour:
- Reset is synchronous: reset = 0 at a rising clk edge resets the block. The edge that samples reset low overrides every other event, including a job in progress.
- Reset values:
  - state = IDLE; phase = 0; pos = 0; step_dir = 0.
  - gnt_a, gnt_b, done_a, done_b, step_en and busy are all 0.
  - Internal remaining-step count and divider count are 0.
  - last_owner = B, so A wins the first tie.
- States: IDLE, GRANT, STEP, WAIT, DONE. All outputs are Moore outputs, decoded from registered state and owner.
- IDLE:
  - Requests are sampled only in IDLE.
  - Only one of req_a / req_b high: that client wins.
  - Both high: the client that is not last_owner wins.
  - Neither high: stay in IDLE.
  - On the edge leaving IDLE: latch owner, dir and num from the winner; set last_owner = winner; go to GRANT.
- GRANT:
  - gnt_<owner> = 1 for exactly this one cycle.
  - Latched num == 0: next state is DONE; no step is issued.
  - Otherwise: next state is STEP; remaining = num.
- STEP:
  - step_en = 1 for this one cycle.
  - On the edge leaving STEP:
    - dir = 0: phase = phase + 1 mod 4; pos = pos + 1 mod 2^POS_W.
    - dir = 1: phase = phase - 1 mod 4; pos = pos - 1 mod 2^POS_W.
    - remaining = remaining - 1.
  - Next state:
    - remaining reaches 0: DONE.
    - else if DIV = 1: STEP again (back-to-back pulses).
    - else: WAIT, with the divider loaded to DIV - 1.
  - abort is ignored in STEP; the step in progress always completes.
- WAIT:
  - The divider decrements each cycle.
  - When the divider reaches 1, the next state is STEP. Result: step_en pulses are spaced exactly DIV cycles apart.
  - abort = 1 at any WAIT edge: go to DONE; no further step is issued; remaining is discarded.
- DONE:
  - done_<owner> = 1 for exactly this one cycle.
  - Next state is IDLE.
  - busy = 1 in GRANT, STEP, WAIT and DONE.
- Timing for a job with num = N ≥ 1:
  - The request is sampled at edge e0.
  - gnt pulses in cycle e0+1.
  - First step_en in cycle e0+2.
  - The k-th step_en is in cycle e0+2+(k-1)·DIV.
  - done pulses one cycle after the last step_en.
  - The block returns to IDLE on the following edge.
- Requester rules:
  - dir_x and num_x must be valid while req_x is high. They are captured only on the edge that leaves IDLE.
  - A request still high when the block re-enters IDLE is treated as a new job.
  - A request raised while busy waits; it is not lost as long as the requester holds it.
- Wrap-around: phase wraps 3→0 (increment) and 0→3 (decrement). pos wraps at 2^POS_W with no saturation.
- Consistency: the value of phase always matches an external 2-bit up/down counter that starts from 0 and advances once per step_en in direction step_dir.

Test Plan:
- Reset with DIV = 3: hold reset = 0 for 2 cycles → all outputs 0, busy = 0. Then raise req_a alone with dir_a = 0, num_a = 3 → gnt_a 1 cycle later; step_en at cycles +2, +5, +8; phase 1, 2, 3; pos = 3; done_a at +9.
- Both requests high in the same IDLE cycle: A (dir = 1, num = 1) and B (dir = 0, num = 1) → A is granted first. phase 0→3, pos = 0xFF. Then B is granted; phase 3→0, pos = 0x00. With both requests held, grants alternate A, B, A.
- req_b with num_b = 0 → gnt_b, then done_b on the next cycle. No step_en, phase and pos unchanged, back to IDLE.
- A job with num = 5, DIV = 3; assert abort for 1 cycle during the WAIT after the 2nd step → exactly 2 step_en pulses, phase = 2, done_a on the next cycle. abort asserted only in a STEP cycle → the step still completes.
- reset driven low during the WAIT of a num = 4 job → on the next edge: state IDLE, phase = 0, pos = 0, no done pulse, busy = 0.
- DIV = 1 with num = 4 → step_en high for 4 consecutive cycles and phase wraps 0→1→2→3→0.
